// File: rtl/uart_word_tx.sv
// Serializes a 32-bit word as NUM_BYTES back-to-back UART 8N1 frames, LSB byte and LSB bit first.
// The final stop bit overlaps the IDLE cycle, so a word offered on that cycle starts with no gap.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line high, word_ready=1; also the last cycle of the final stop bit
// START | start bit (tx=0) of the current byte
// DATA  | data bit bit_q of the current byte, taken from shift_q[0]
// STOP  | stop bit (tx=1); then the next byte's START, or IDLE after the last byte
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int NUM_BYTES    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx,
    output logic        busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_TAIL = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [1:0]       BYTE_LAST = 2'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [31:0]      shift_q, shift_d;
    logic             tx_d;
    logic             baud_end;
    logic             stop_end;

    assign word_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign baud_end   = (baud_q == BAUD_LAST);
    // The last stop bit ends one cycle early in STOP; the IDLE cycle supplies its final cycle.
    assign stop_end   = (byte_q == BYTE_LAST) ? (baud_q == BAUD_TAIL) : baud_end;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (word_valid) begin
                    state_d = START;
                    shift_d = word_in;
                    baud_d  = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (stop_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (4 clk/bit x 4 bytes, 2 clk/bit x 1 byte).
// Stimulus pushes expected bytes into per-instance queues; UART decoders pop and compare.
module tb_uart_word_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, word_valid_a, word_ready_a, tx_a, busy_a;
    logic [31:0] word_in_a;
    logic        rst_n_b, word_valid_b, word_ready_b, tx_b, busy_b;
    logic [31:0] word_in_b;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    uart_word_tx #(.CLKS_PER_BIT(4), .NUM_BYTES(4)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .word_in(word_in_a), .word_valid(word_valid_a),
        .word_ready(word_ready_a), .tx(tx_a), .busy(busy_a)
    );

    uart_word_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .word_in(word_in_b), .word_valid(word_valid_b),
        .word_ready(word_ready_b), .tx(tx_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction
    function automatic logic get_rst(input int sel);
        return (sel != 0) ? rst_n_b : rst_n_a;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel != 0) ? word_ready_b : word_ready_a;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] w);
        if (sel != 0) begin
            word_valid_b = v;
            word_in_b    = w;
        end else begin
            word_valid_a = v;
            word_in_a    = w;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge with word_valid still high.
    task automatic accept(input int sel, input logic [31:0] w);
        bit ok = 1'b0;
        drive(sel, 1'b1, w);
        for (int i = 0; i < 2000; i++) begin
            if (get_ready(sel)) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check((sel != 0) ? "accept_b" : "accept_a", 32'(ok), 32'd1);
    endtask

    // Counts transfer cycles, the first cycle after accept being 1, up to and including the ready cycle.
    task automatic wait_ready(input int sel, output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            n++;
            if (get_ready(sel)) return;
            @(posedge clk);
            #1;
        end
        n = -1;
    endtask

    task automatic steps(input int sel, input int n, inout logic ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!get_rst(sel)) ab = 1'b1;
        end
    endtask

    // Entered on the negedge of the first start-bit cycle.
    task automatic decode_frame(input int sel, input int c, output logic ab,
                                output logic [7:0] b, output logic st_ok, output logic stop_bit);
        ab = 1'b0; st_ok = 1'b1; b = '0; stop_bit = 1'b0;
        for (int k = 1; k < c; k++) begin
            @(negedge clk);
            if (!get_rst(sel)) begin ab = 1'b1; return; end
            if (get_tx(sel) !== 1'b0) st_ok = 1'b0;
        end
        steps(sel, c / 2 + 1, ab);
        if (ab) return;
        b[0] = get_tx(sel);
        for (int i = 1; i < 8; i++) begin
            steps(sel, c, ab);
            if (ab) return;
            b[i] = get_tx(sel);
        end
        steps(sel, c, ab);
        if (ab) return;
        stop_bit = get_tx(sel);
    endtask

    task automatic decoder(input int sel);
        int c = (sel != 0) ? 2 : 4;
        logic ab, st_ok, stop_bit;
        logic [7:0] b, e;
        forever begin
            @(negedge clk);
            if (!get_rst(sel) || get_tx(sel) !== 1'b0) continue;
            decode_frame(sel, c, ab, b, st_ok, stop_bit);
            if (ab) continue;
            if ((sel != 0) ? (exp_q_b.size() == 0) : (exp_q_a.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s: got frame %0h expected no frame", (sel != 0) ? "extra_frame_b" : "extra_frame_a", b);
                continue;
            end
            e = (sel != 0) ? exp_q_b.pop_front() : exp_q_a.pop_front();
            check((sel != 0) ? "rx_byte_b" : "rx_byte_a", 32'(b), 32'(e));
            check((sel != 0) ? "start_len_b" : "start_len_a", 32'(st_ok), 32'd1);
            check((sel != 0) ? "stop_bit_b" : "stop_bit_a", 32'(stop_bit), 32'd1);
        end
    endtask

    initial decoder(0);
    initial decoder(1);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n2;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        drive(0, 1'b1, 32'h1111_2222);
        drive(1, 1'b0, 32'h0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_tx", 32'(tx_a), 32'd1);
            check("rst_ready", 32'(word_ready_a), 32'd1);
            check("rst_busy", 32'(busy_a), 32'd0);
        end
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(posedge clk);
        #1;
        check("no_accept_in_reset_busy", 32'(busy_a), 32'd0);
        check("no_accept_in_reset_ready", 32'(word_ready_a), 32'd1);

        // single word
        exp_q_a.push_back(8'h44); exp_q_a.push_back(8'h43);
        exp_q_a.push_back(8'h42); exp_q_a.push_back(8'h41);
        accept(0, 32'h4142_4344);
        drive(0, 1'b0, 32'h0);
        check("single_first_tx", 32'(tx_a), 32'd0);
        check("single_busy", 32'(busy_a), 32'd1);
        wait_ready(0, n);
        check("single_ready_cycles", 32'(n), 32'd160);
        check("single_busy_at_ready", 32'(get_busy(0)), 32'd0);

        // back-to-back with word_valid held high
        exp_q_a.push_back(8'hFF);
        for (int i = 0; i < 7; i++) exp_q_a.push_back(8'h00);
        accept(0, 32'h0000_00FF);
        drive(0, 1'b1, 32'h0);
        wait_ready(0, n1);
        check("b2b_first_cycles", 32'(n1), 32'd160);
        check("b2b_stop_high", 32'(tx_a), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_second_accept", 32'(word_ready_a), 32'd0);
        check("b2b_no_idle_gap", 32'(tx_a), 32'd0);
        drive(0, 1'b0, 32'h0);
        wait_ready(0, n2);
        check("b2b_total_cycles", 32'(n1 + n2), 32'd320);

        // backpressure: mid-transfer offer must be ignored
        exp_q_a.push_back(8'h3C); exp_q_a.push_back(8'h7E);
        exp_q_a.push_back(8'h01); exp_q_a.push_back(8'h80);
        accept(0, 32'h8001_7E3C);
        drive(0, 1'b0, 32'h8001_7E3C);
        repeat (70) begin @(posedge clk); #1; end
        drive(0, 1'b1, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'hDEAD_BEEF);
        wait_ready(0, n);
        check("bp_ready_cycles", 32'(n), 32'd89);
        repeat (60) begin @(posedge clk); #1; end
        check("bp_idle_busy", 32'(busy_a), 32'd0);
        check("bp_idle_tx", 32'(tx_a), 32'd1);
        check("bp_queue_empty", 32'(exp_q_a.size()), 32'd0);

        // reset during bit 3 of byte 1 (byte 1 = 0x96, bit 3 = 0)
        exp_q_a.push_back(8'h55);
        accept(0, 32'hC3A5_9655);
        drive(0, 1'b0, 32'h0);
        repeat (57) begin @(posedge clk); #1; end
        check("pre_reset_bit3", 32'(tx_a), 32'd0);
        rst_n_a = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_tx", 32'(tx_a), 32'd1);
        check("midrst_busy", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_after", 32'(word_ready_a), 32'd1);
        exp_q_a.push_back(8'h78); exp_q_a.push_back(8'h56);
        exp_q_a.push_back(8'h34); exp_q_a.push_back(8'h12);
        accept(0, 32'h1234_5678);
        drive(0, 1'b0, 32'h0);
        wait_ready(0, n);
        check("post_rst_ready_cycles", 32'(n), 32'd160);
        repeat (20) begin @(posedge clk); #1; end
        check("a_queue_empty", 32'(exp_q_a.size()), 32'd0);

        // single byte instance
        exp_q_b.push_back(8'h55);
        accept(1, 32'hAAAA_AA55);
        drive(1, 1'b0, 32'h0);
        check("b_first_tx", 32'(tx_b), 32'd0);
        wait_ready(1, n);
        check("b_ready_cycles", 32'(n), 32'd20);
        repeat (40) begin @(posedge clk); #1; end
        check("b_idle_busy", 32'(busy_b), 32'd0);
        check("b_idle_tx", 32'(tx_b), 32'd1);
        check("b_queue_empty", 32'(exp_q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
